ascon_perm_seq: RTL and testbench

- Iterative sequencer for the ASCON permutation p^a.
- Drives one external single-round datapath (inputs s and C, output s_rout) repeatedly over a held 320-bit state register. Performs 12, 8 or 6 rounds per request, with round constants generated on chip.
- Replaces a fully unrolled chain of round instances when area matters. Sits between the mode FSM (init / associated data / finalisation) and the round core.

---
 rtl/ascon_perm_seq.sv | 100 ++++++++++
 tb/tb_ascon_perm_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_seq.sv
// Iterative ASCON p^a sequencer: runs 12, 8 or 6 rounds of an external
// single-round core over a held 320-bit state, generating round constants.
module ascon_perm_seq #(
    parameter int unsigned RND_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   rounds,
    input  logic [319:0] s_in,
    output logic         busy,
    output logic         done,
    output logic [319:0] s_out,
    output logic [319:0] r_s,
    output logic [7:0]   r_C,
    input  logic [319:0] r_s_rout
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // Wait-counter value on which the round core output is captured.
    localparam logic [1:0] WcLast = 2'(RND_LAT - 1);

    state_e         state_q, state_d;
    logic [319:0]   st_q, st_d;
    logic [3:0]     ri_q, ri_d;
    logic [1:0]     wc_q, wc_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    assign busy  = busy_q;
    assign done  = done_q;
    assign s_out = st_q;
    assign r_s   = st_q;

    // Round constant from the round index; quiet in idle.
    assign r_C = (state_q == StRun) ? {4'hF - ri_q, ri_q} : 8'h00;

    // Next-state logic: accept requests in idle, step rounds in run.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        ri_d    = ri_q;
        wc_d    = wc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    st_d    = s_in;
                    wc_d    = 2'd0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                    case (rounds)
                        2'b01:   ri_d = 4'd4;
                        2'b10:   ri_d = 4'd6;
                        default: ri_d = 4'd0;
                    endcase
                end
            end
            StRun: begin
                if (wc_q == WcLast) begin
                    st_d = r_s_rout;
                    wc_d = 2'd0;
                    if (ri_q == 4'd11) begin
                        ri_d    = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ri_d = ri_q + 4'd1;
                    end
                end else begin
                    wc_d = wc_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            st_q    <= '0;
            ri_q    <= 4'd0;
            wc_q    <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            ri_q    <= ri_d;
            wc_q    <= wc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ascon_perm_seq.sv
// Bench for ascon_perm_seq: one instance on a combinational round core
// (RND_LAT=1), one on a registered round core (RND_LAT=2), both checked
// against a reference that iterates the ASCON round function directly.
module tb_ascon_perm_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   rounds;
    logic [319:0] s_in;

    logic         busy1, done1, busy2, done2;
    logic [319:0] s_out1, r_s1, rout1, s_out2, r_s2, rout2, rout2_q;
    logic [7:0]   r_C1, r_C2;

    logic         glitch;
    logic [319:0] glitch_val;

    int n_checks = 0;
    int n_errors = 0;

    ascon_perm_seq #(.RND_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .rounds(rounds), .s_in(s_in),
        .busy(busy1), .done(done1), .s_out(s_out1), .r_s(r_s1), .r_C(r_C1),
        .r_s_rout(rout1)
    );

    ascon_perm_seq #(.RND_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .rounds(rounds), .s_in(s_in),
        .busy(busy2), .done(done2), .s_out(s_out2), .r_s(r_s2), .r_C(r_C2),
        .r_s_rout(rout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One ASCON round: constant addition, 5-bit S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [7:0] c);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, c};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Constant of round i of 12: F0, E1, ... steps of -0x0F.
    function automatic logic [7:0] rc_of(input int i);
        return 8'hF0 - 8'(i * 15);
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input int n);
        logic [319:0] t = s;
        for (int i = 12 - n; i < 12; i++) t = ascon_round(t, rc_of(i));
        return t;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v = '0;
        for (int i = 0; i < 10; i++) v = {v[287:0], 32'($urandom)};
        return v;
    endfunction

    // Round cores: combinational, and registered with one cycle of latency.
    always_comb rout1 = glitch ? glitch_val : ascon_round(r_s1, r_C1);
    always_ff @(posedge clk) rout2_q <= ascon_round(r_s2, r_C2);
    always_comb rout2 = glitch ? glitch_val : rout2_q;

    task automatic check_eq(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " busy1"}, 320'(busy1), 320'd0);
        check_eq({tag, " done1"}, 320'(done1), 320'd0);
        check_eq({tag, " busy2"}, 320'(busy2), 320'd0);
        check_eq({tag, " done2"}, 320'(done2), 320'd0);
    endtask

    // One request seen by both instances; start is also pulsed mid-run.
    task automatic run_cmp(input logic [1:0] rsel, input logic [319:0] sin);
        int n;
        logic [319:0] exp;
        n = (rsel == 2'b01) ? 8 : (rsel == 2'b10) ? 6 : 12;
        exp = perm(sin, n);
        @(negedge clk);
        start = 1'b1; rounds = rsel; s_in = sin;
        for (int c = 1; c <= 2 * n + 1; c++) begin
            @(negedge clk);
            if (c <= n) begin
                check_eq("rc1", 320'(r_C1), 320'(rc_of(12 - n + c - 1)));
                check_eq("busy1 run", 320'(busy1), 320'd1);
                check_eq("done1 run", 320'(done1), 320'd0);
            end else if (c == n + 1) begin
                check_eq("done1 pulse", 320'(done1), 320'd1);
                check_eq("busy1 end", 320'(busy1), 320'd0);
                check_eq("s_out1", s_out1, exp);
                check_eq("r_s1", r_s1, exp);
                check_eq("rc1 idle", 320'(r_C1), 320'd0);
            end else begin
                check_eq("done1 after", 320'(done1), 320'd0);
                check_eq("busy1 after", 320'(busy1), 320'd0);
                check_eq("s_out1 hold", s_out1, exp);
            end
            if (c <= 2 * n) begin
                check_eq("rc2", 320'(r_C2), 320'(rc_of(12 - n + (c - 1) / 2)));
                check_eq("busy2 run", 320'(busy2), 320'd1);
                check_eq("done2 run", 320'(done2), 320'd0);
            end else begin
                check_eq("done2 pulse", 320'(done2), 320'd1);
                check_eq("busy2 end", 320'(busy2), 320'd0);
                check_eq("s_out2", s_out2, exp);
            end
            start = (c == 2);
            s_in = rand320();
            rounds = 2'($urandom);
        end
        start = 1'b0;
    endtask

    logic [319:0] sin_hist [0:21];
    logic [319:0] hold1, hold2;

    initial begin
        rst = 1'b1; start = 1'b0; rounds = 2'b00; s_in = '0;
        glitch = 1'b0; glitch_val = '0;

        // Reset asserted mid-cycle, held three cycles.
        #12 rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("reset");
        check_eq("reset s_out1", s_out1, '0);
        check_eq("reset s_out2", s_out2, '0);
        check_eq("reset rc1", 320'(r_C1), 320'd0);
        check_eq("reset rc2", 320'(r_C2), 320'd0);

        run_cmp(2'b10, rand320());
        run_cmp(2'b00, rand320());
        run_cmp(2'b01, rand320());
        run_cmp(2'b11, rand320());
        for (int k = 0; k < 3; k++) run_cmp(2'b10, rand320());

        // Result hold while the round core output toggles.
        hold1 = s_out1; hold2 = s_out2;
        glitch = 1'b1;
        for (int c = 0; c < 20; c++) begin
            glitch_val = rand320();
            @(negedge clk);
            check_eq("hold s_out1", s_out1, hold1);
            check_eq("hold s_out2", s_out2, hold2);
            check_idle("hold");
        end
        glitch = 1'b0;

        // start held high: p6 back-to-back, done every 7th cycle.
        @(negedge clk);
        start = 1'b1; rounds = 2'b10; s_in = rand320(); sin_hist[0] = s_in;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            if (c % 7 == 0) begin
                check_eq("cont done1", 320'(done1), 320'd1);
                check_eq("cont busy1", 320'(busy1), 320'd0);
                check_eq("cont s_out1", s_out1, perm(sin_hist[c - 7], 6));
            end else begin
                check_eq("cont done1 low", 320'(done1), 320'd0);
                check_eq("cont busy1 high", 320'(busy1), 320'd1);
            end
            s_in = rand320(); sin_hist[c] = s_in;
            start = (c < 21);
        end
        start = 1'b0;
        repeat (30) @(negedge clk);
        check_idle("cont drain");

        // Reset during a p12 run aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1; rounds = 2'b00; s_in = rand320();
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_idle("abort");
        check_eq("abort s_out1", s_out1, '0);
        check_eq("abort rc2", 320'(r_C2), 320'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check_idle("post abort");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
